// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the Harvard CPU data-port memory responder.
package mips_mem_pkg;

    typedef enum logic {IDLE, WAIT} mem_state_t;

    localparam int unsigned WORD_BYTES = 4;
    localparam logic [31:0] MISALIGN_PATTERN = 32'hDEAD_BEEF;

    // Everything that identifies a request; compared against the held copy while stalled.
    typedef struct packed {
        logic        read;
        logic        write;
        logic [31:0] address;
        logic [3:0]  byteenable;
        logic [31:0] writedata;
    } mem_cmd_t;

endpackage

// File: rtl/data_mem_responder_byte_ram_lane.sv
// One 8-bit byte lane of the data RAM: asynchronous read, synchronous write with enable.
module byte_ram_lane #(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data-port memory responder with programmable wait states and byte-lane writes.
// Optional feature macro: DATA_RAM_ALIGN_CHECK_EN (flag misaligned accesses as errors).
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int unsigned WORD_ADDR_BITS = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
    parameter int unsigned WAIT_STATES    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        data_waitrequest,
    output logic        data_err
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    mem_state_t                state, state_next;
    logic [3:0]                cnt, cnt_next;
    mem_cmd_t                  cur, held, held_next;
    logic                      req, stale, complete;
    logic                      in_range, dual, misalign, illegal;
    logic [29:0]               word_off;
    logic [WORD_ADDR_BITS-1:0] word;
    logic [WORD_BYTES-1:0]     lane_we;
    logic [31:0]               ram_rdata;

    assign req   = data_read | data_write;
    assign cur   = {data_read, data_write, data_address, data_byteenable, data_writedata};
    assign stale = (state == WAIT) && (cur != held);

    // BASE_ADDR is word-aligned, so the offset can be taken on word addresses directly.
    assign word_off = data_address[31:2] - BASE_ADDR[31:2];
    assign in_range = (data_address >= BASE_ADDR) && ((word_off >> WORD_ADDR_BITS) == '0);
    assign word     = word_off[WORD_ADDR_BITS-1:0];
    assign dual     = data_read & data_write;
`ifdef DATA_RAM_ALIGN_CHECK_EN
    assign misalign = |data_address[1:0];
`else
    assign misalign = 1'b0;
`endif
    assign illegal  = ~in_range | dual | misalign;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            held  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            held  <= held_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        held_next  = held;
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (req && (WAIT_STATES != 0)) begin
                    state_next = WAIT;
                    cnt_next   = 4'd1;
                    held_next  = cur;
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (stale) begin
                    cnt_next  = '0;
                    held_next = cur;
                end else if (cnt == WAIT_CNT) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 4'd1;
                end
            end
        endcase
    end

    // A changed request never completes in the same cycle, even if the count has run out.
    always_comb begin
        if (!reset) begin
            data_waitrequest = req && (WAIT_STATES != 0);
        end else begin
            data_waitrequest = req && ((cnt != WAIT_CNT) || stale);
        end
        complete      = reset && req && !data_waitrequest;
        lane_we       = (complete && data_write && !illegal) ? data_byteenable : '0;
        data_err      = complete && illegal;
        data_readdata = '0;
        if (complete && data_read && !data_write) begin
            if (!in_range) begin
                data_readdata = '0;
            end else if (misalign) begin
                data_readdata = MISALIGN_PATTERN;
            end else begin
                data_readdata = ram_rdata;
            end
        end
    end

    for (genvar i = 0; i < WORD_BYTES; i++) begin : g_lane
        byte_ram_lane #(
            .ADDR_BITS(WORD_ADDR_BITS)
        ) u_lane (
            .clk  (clk),
            .we   (lane_we[i]),
            .addr (word),
            .wdata(data_writedata[8*i +: 8]),
            .rdata(ram_rdata[8*i +: 8])
        );
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (0, 2 and 3 wait states), directed vector table
// plus randomized traffic checked against a cycle-level reference model.
module tb_data_mem_responder;

`ifdef DATA_RAM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int NO = 0, RD = 1, WR = 2, RW = 3;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } cmd_t;

    typedef struct {
        bit          rst_n;
        int          d;
        int          op;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        ew;
        logic [31:0] erd;
        logic        er;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    cmd_t        cur [3];
    logic [2:0]  wreq, errs;
    logic [31:0] rdat [3];

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state: per-instance wait budget, progress and memory image.
    int          ws [3] = '{0, 2, 3};
    bit          busy [3];
    int          age [3];
    cmd_t        last [3];
    logic [31:0] mm [3][1024];
    vec_t        tbl [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned WSG = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        data_mem_responder #(
            .WORD_ADDR_BITS(10),
            .BASE_ADDR     (32'h0000_1000),
            .WAIT_STATES   (WSG)
        ) u_dut (
            .clk             (clk),
            .reset           (rstn),
            .data_read       (cur[g].rd),
            .data_write      (cur[g].wr),
            .data_address    (cur[g].addr),
            .data_byteenable (cur[g].be),
            .data_writedata  (cur[g].wd),
            .data_readdata   (rdat[g]),
            .data_waitrequest(wreq[g]),
            .data_err        (errs[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of the responder as described behaviourally: a request completes once it has
    // been presented unchanged for its full wait budget; a change mid-stall restarts the budget.
    task automatic model(input int i, output logic ew, output logic [31:0] erd,
                         output logic er, output bit comp);
        cmd_t c;
        bit req, changed, inr, mis, bad;
        int unsigned idx;
        c = cur[i];
        req = c.rd || c.wr;
        ew = 1'b0; erd = '0; er = 1'b0; comp = 1'b0;
        if (!rstn) begin
            ew = req && (ws[i] != 0);
            busy[i] = 1'b0; age[i] = 0;
            return;
        end
        if (!req) begin
            busy[i] = 1'b0; age[i] = 0;
            return;
        end
        changed = busy[i] && (c != last[i]);
        ew = changed || (age[i] != ws[i]);
        comp = !ew;
        if (comp) begin
            inr = (c.addr >= BASE) && (c.addr < BASE + 32'd4096);
            mis = ALIGN_EN && (c.addr[1:0] != 2'b00);
            bad = !inr || (c.rd && c.wr) || mis;
            er = bad;
            idx = (c.addr - BASE) >> 2;
            if (c.rd && !c.wr && inr) erd = mis ? 32'hDEAD_BEEF : mm[i][idx];
            if (c.wr && !bad)
                for (int b = 0; b < 4; b++)
                    if (c.be[b]) mm[i][idx][8*b +: 8] = c.wd[8*b +: 8];
            busy[i] = 1'b0; age[i] = 0;
        end else if (changed) begin
            age[i] = 0; last[i] = c;
        end else if (!busy[i]) begin
            busy[i] = 1'b1; age[i] = 1; last[i] = c;
        end else begin
            age[i]++;
        end
    endtask

    // Drive one cycle on instance d (others idle), check all instances against the model.
    task automatic step(input int d, input cmd_t c, output logic o_wr, output logic [31:0] o_rd,
                        output logic o_err, output bit o_comp);
        for (int i = 0; i < 3; i++) cur[i] = (i == d) ? c : '0;
        #1;
        o_comp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            logic ew, er;
            logic [31:0] erd;
            bit comp;
            model(i, ew, erd, er, comp);
            chk($sformatf("model d%0d waitrequest", i), {31'b0, wreq[i]}, {31'b0, ew});
            chk($sformatf("model d%0d readdata", i), rdat[i], erd);
            chk($sformatf("model d%0d err", i), {31'b0, errs[i]}, {31'b0, er});
            if (i == d) o_comp = comp;
        end
        o_wr = wreq[d]; o_rd = rdat[d]; o_err = errs[d];
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic cmd_t mkcmd(input int op, input logic [31:0] a, input logic [3:0] be,
                                   input logic [31:0] wd);
        cmd_t c;
        c.rd = op[0]; c.wr = op[1]; c.addr = a; c.be = be; c.wd = wd;
        return c;
    endfunction

    function automatic void add(input bit rn, input int d, input int op, input logic [31:0] a,
                                input logic [3:0] be, input logic [31:0] wd,
                                input logic ew, input logic [31:0] erd, input logic er);
        vec_t v;
        v.rst_n = rn; v.d = d; v.op = op; v.addr = a; v.be = be; v.wd = wd;
        v.ew = ew; v.erd = erd; v.er = er;
        tbl.push_back(v);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0:       return 32'h0000_0FFC;
            1:       return 32'h0000_2000;
            2:       return 32'hFFFF_FFFC;
            3:       return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            default: return BASE + 32'(4 * $urandom_range(0, 15));
        endcase
    endfunction

    function automatic cmd_t rand_cmd();
        int r;
        r = $urandom_range(0, 19);
        return mkcmd((r < 3) ? NO : (r < 11) ? RD : (r < 19) ? WR : RW,
                     rand_addr(), 4'($urandom_range(0, 15)), $urandom());
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic w, e;
        logic [31:0] r;
        bit comp;
        cmd_t c;

        // Zero-wait instance: write, read back, reset edge must not commit.
        add(1, 0, WR, 32'h1000, 4'hF, 32'h1234_5678, 0, 32'h0, 0);
        add(1, 0, RD, 32'h1000, 4'hF, 32'h0,         0, 32'h1234_5678, 0);
        add(0, 0, WR, 32'h1000, 4'hF, 32'h0,         0, 32'h0, 0);
        add(1, 0, RD, 32'h1000, 4'hF, 32'h0,         0, 32'h1234_5678, 0);
        // Byte lanes, and an empty lane mask.
        add(1, 0, WR, 32'h1008, 4'hF, 32'hAAAA_AAAA, 0, 32'h0, 0);
        add(1, 0, WR, 32'h1008, 4'h5, 32'h1122_3344, 0, 32'h0, 0);
        add(1, 0, RD, 32'h1008, 4'hF, 32'h0,         0, 32'hAA22_AA44, 0);
        add(1, 0, WR, 32'h1008, 4'h0, 32'hFFFF_FFFF, 0, 32'h0, 0);
        add(1, 0, RD, 32'h1008, 4'hF, 32'h0,         0, 32'hAA22_AA44, 0);
        // Illegal accesses and the window edges.
        add(1, 0, RD, 32'h0FFC, 4'hF, 32'h0,         0, 32'h0, 1);
        add(1, 0, RW, 32'h1000, 4'hF, 32'hFFFF_FFFF, 0, 32'h0, 1);
        add(1, 0, RD, 32'h1000, 4'hF, 32'h0,         0, 32'h1234_5678, 0);
        add(1, 0, WR, 32'h2000, 4'hF, 32'h0BAD_0BAD, 0, 32'h0, 1);
        add(1, 0, WR, 32'h1FFC, 4'hF, 32'hDEAD_BEE0, 0, 32'h0, 0);
        add(1, 0, RD, 32'h1FFC, 4'hF, 32'h0,         0, 32'hDEAD_BEE0, 0);
        add(1, 0, RD, 32'h1001, 4'hF, 32'h0, 0, ALIGN_EN ? 32'hDEAD_BEEF : 32'h1234_5678, ALIGN_EN);
        add(1, 0, WR, 32'h1001, 4'hF, 32'h0, 0, 32'h0, ALIGN_EN);
        add(1, 0, RD, 32'h1000, 4'hF, 32'h0, 0, ALIGN_EN ? 32'h1234_5678 : 32'h0, 0);
        // Three wait states: write then read held until completion.
        for (int k = 0; k < 4; k++) add(1, 2, WR, 32'h1004, 4'hF, 32'hCAFE_F00D, k < 3, 32'h0, 0);
        for (int k = 0; k < 4; k++) add(1, 2, RD, 32'h1004, 4'hF, 32'h0, k < 3, (k == 3) ? 32'hCAFE_F00D : 32'h0, 0);
        // Two wait states: address change restarts the count.
        for (int k = 0; k < 3; k++) add(1, 1, WR, 32'h100C, 4'hF, 32'h0101_0101, k < 2, 32'h0, 0);
        for (int k = 0; k < 3; k++) add(1, 1, WR, 32'h1010, 4'hF, 32'h0202_0202, k < 2, 32'h0, 0);
        add(1, 1, WR, 32'h100C, 4'hF, 32'h5555_5555, 1, 32'h0, 0);
        for (int k = 0; k < 4; k++) add(1, 1, WR, 32'h1010, 4'hF, 32'h5555_5555, k < 3, 32'h0, 0);
        for (int k = 0; k < 3; k++) add(1, 1, RD, 32'h100C, 4'hF, 32'h0, k < 2, (k == 2) ? 32'h0101_0101 : 32'h0, 0);
        for (int k = 0; k < 3; k++) add(1, 1, RD, 32'h1010, 4'hF, 32'h0, k < 2, (k == 2) ? 32'h5555_5555 : 32'h0, 0);
        // Reset mid-stall abandons the write.
        for (int k = 0; k < 3; k++) add(1, 1, WR, 32'h1000, 4'hF, 32'h1111_1111, k < 2, 32'h0, 0);
        add(1, 1, WR, 32'h1000, 4'hF, 32'h7777_7777, 1, 32'h0, 0);
        add(0, 1, WR, 32'h1000, 4'hF, 32'h7777_7777, 1, 32'h0, 0);
        add(1, 1, NO, 32'h1000, 4'hF, 32'h0,         0, 32'h0, 0);
        for (int k = 0; k < 3; k++) add(1, 1, RD, 32'h1000, 4'hF, 32'h0, k < 2, (k == 2) ? 32'h1111_1111 : 32'h0, 0);

        for (int i = 0; i < 3; i++) cur[i] = '0;
        @(negedge clk);
        // Outputs while held in reset, with and without a pending request.
        step(0, '0, w, r, e, comp);
        chk("reset idle waitrequest", {31'b0, w}, 32'h0);
        step(1, mkcmd(RD, 32'h1000, 4'hF, 32'h0), w, r, e, comp);
        chk("reset req waitrequest ws2", {31'b0, w}, 32'h1);
        step(0, mkcmd(RD, 32'h1000, 4'hF, 32'h0), w, r, e, comp);
        chk("reset req waitrequest ws0", {31'b0, w}, 32'h0);
        chk("reset readdata", r, 32'h0);
        chk("reset err", {31'b0, e}, 32'h0);
        rstn = 1'b1;

        foreach (tbl[n]) begin
            rstn = tbl[n].rst_n;
            step(tbl[n].d, mkcmd(tbl[n].op, tbl[n].addr, tbl[n].be, tbl[n].wd), w, r, e, comp);
            chk($sformatf("vec%0d waitrequest", n), {31'b0, w}, {31'b0, tbl[n].ew});
            chk($sformatf("vec%0d readdata", n), r, tbl[n].erd);
            chk($sformatf("vec%0d err", n), {31'b0, e}, {31'b0, tbl[n].er});
        end
        rstn = 1'b1;

        // Give every word used by random traffic a known value.
        for (int d = 0; d < 3; d++)
            for (int wi = 0; wi < 16; wi++) begin
                c = mkcmd(WR, BASE + 32'(4 * wi), 4'hF, $urandom());
                for (int k = 0; k <= ws[d]; k++) step(d, c, w, r, e, comp);
            end

        for (int d = 0; d < 3; d++) begin
            c = '0;
            comp = 1'b1;
            for (int n = 0; n < 300; n++) begin
                int q;
                q = $urandom_range(0, 19);
                if (comp || !(c.rd || c.wr)) c = rand_cmd();
                else if (q == 0) c = '0;
                else if (q == 1) c.addr = rand_addr();
                else if (q == 2) c.wd = $urandom();
                step(d, c, w, r, e, comp);
            end
            step(d, '0, w, r, e, comp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
